lsu: RTL

//  Load/store unit between the execute stage and the data memory. Accepts one

---
 rtl/lsu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one request at a time, checks funct3/alignment, holds the
// memory port for MEM_LAT cycles, extends load data, holds the response until retired.
module lsu #(
   parameter int unsigned MEM_LAT     = 1,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [4:0]  req_rd_i,
   output logic        mem_we_o,
   output logic [2:0]  mem_mode_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic [4:0]  resp_rd_o,
   output logic        resp_err_o,
   output logic [31:0] resp_err_addr_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        err;
      logic [31:0] err_addr;
   } resp_t;

   localparam int unsigned   CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   req_t          req_q, req_d;
   resp_t         resp_q, resp_d;

   logic illegal, misaligned;
   logic [31:0] ext_data;

   // Stores only have B/H/W; loads additionally have BU/HU.
   always_comb begin
      if (req_we_i)
         illegal = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
      else
         illegal = (req_funct3_i[1:0] == 2'b11) | (req_funct3_i[2:1] == 2'b11);
   end

   assign misaligned = CHECK_ALIGN &&
                       (((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00)));

   always_comb begin
      case (req_q.funct3)
         3'b000:  ext_data = {{24{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
         3'b001:  ext_data = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
         3'b100:  ext_data = {24'h0, mem_rdata_i[7:0]};
         3'b101:  ext_data = {16'h0, mem_rdata_i[15:0]};
         default: ext_data = mem_rdata_i;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_d         = req_q;
      resp_d        = resp_q;
      req_ready_o   = 1'b0;
      mem_we_o      = 1'b0;
      mem_mode_o    = 3'b000;
      mem_address_o = 32'h0;
      mem_wdata_o   = 32'h0;
      resp_valid_o  = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               req_d.we     = req_we_i;
               req_d.funct3 = req_funct3_i;
               req_d.addr   = req_addr_i;
               req_d.wdata  = req_wdata_i;
               req_d.rd     = req_rd_i;
               if (illegal || misaligned) begin
                  state_d         = RESP;
                  resp_d.rdata    = 32'h0;
                  resp_d.rd       = req_we_i ? 5'd0 : req_rd_i;
                  resp_d.err      = 1'b1;
                  resp_d.err_addr = req_addr_i;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = '0;
               end
            end
         end
         ACCESS: begin
            // funct3[1:0] encodes size: 00 byte, 01 half, 10 word.
            mem_mode_o    = {req_q.funct3[1:0] == 2'b10, req_q.funct3[1:0] == 2'b01,
                             req_q.funct3[1:0] == 2'b00};
            mem_address_o = req_q.addr;
            mem_wdata_o   = req_q.wdata;
            mem_we_o      = req_q.we && (cnt_q == '0);
            if (cnt_q == LAST) begin
               state_d         = RESP;
               resp_d.rdata    = req_q.we ? 32'h0 : ext_data;
               resp_d.rd       = req_q.we ? 5'd0 : req_q.rd;
               resp_d.err      = 1'b0;
               resp_d.err_addr = 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_rdata_o    = resp_q.rdata;
   assign resp_rd_o       = resp_q.rd;
   assign resp_err_o      = resp_q.err;
   assign resp_err_addr_o = resp_q.err_addr;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         resp_q  <= resp_d;
      end
   end

endmodule
